// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and default frame parameters for the uart receive path.
package uart_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
    localparam int DBIT_DEF = 8;
    localparam int OVS_DEF = 16;
    localparam int SB_TICK_DEF = 16;
endpackage

// File: rtl/uart_rx_sample_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for the idle-high rx line, resets to 1.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_sample_ctrl.sv
// uart_rx_sample_ctrl: oversampled uart receiver FSM with a 1-entry valid/ready holding register.
module uart_rx_sample_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF,
    parameter int OVS = OVS_DEF,
    parameter int SB_TICK = SB_TICK_DEF
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            overrun
);
    localparam int SW = $clog2(OVS > SB_TICK ? OVS : SB_TICK);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] HALF_END = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_END = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_END = NW'(DBIT - 1);
    state_t state, state_n;
    logic [SW-1:0] s_cnt, s_cnt_n;
    logic [NW-1:0] n, n_n;
    logic [DBIT-1:0] sr, sr_n;
    logic rx_s, seen_high, push, ferr;
    sync_2ff u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_n = n;
        sr_n = sr;
        push = 1'b0;
        ferr = 1'b0;
        case (state)
            ST_IDLE: if (!rx_s && seen_high) begin
                state_n = ST_START;
                s_cnt_n = '0;
            end
            ST_START: if (s_tick) begin
                if (s_cnt == HALF_END) begin
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                    s_cnt_n = '0;
                    n_n = '0;
                end else s_cnt_n = s_cnt + SW'(1);
            end
            ST_DATA: if (s_tick) begin
                if (s_cnt == BIT_END) begin
                    sr_n = {rx_s, sr[DBIT-1:1]};
                    s_cnt_n = '0;
                    state_n = (n == N_END) ? ST_STOP : ST_DATA;
                    n_n = (n == N_END) ? n : n + NW'(1);
                end else s_cnt_n = s_cnt + SW'(1);
            end
            ST_STOP: if (s_tick) begin
                if (s_cnt == STOP_END) begin
                    state_n = ST_IDLE;
                    push = rx_s;
                    ferr = !rx_s;
                end else s_cnt_n = s_cnt + SW'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end
    // seen_high blocks a held-low break line from retriggering a frame after its frame error
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= ST_IDLE;
            s_cnt <= '0;
            n <= '0;
            sr <= '0;
            seen_high <= 1'b0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            s_cnt <= s_cnt_n;
            n <= n_n;
            sr <= sr_n;
            seen_high <= ferr ? 1'b0 : (rx_s | seen_high);
            frame_err <= ferr;
            overrun <= push && rx_valid && !rx_ready;
            if (push && (!rx_valid || rx_ready)) begin
                rx_data <= sr;
                rx_valid <= 1'b1;
            end else if (rx_ready) rx_valid <= 1'b0;
        end
endmodule
